// File: rtl/game_pkg.sv
// Shared playfield geometry, lives defaults and the collision-monitor state type.
package game_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned LEN_W       = 2;
    localparam int unsigned H_DISPLAY   = 640;
    localparam int unsigned TILE        = 16;
    localparam int unsigned CAR_H       = 16;
    localparam int unsigned FROG_SIZE   = 16;
    localparam int unsigned LIVES_INIT  = 3;
    localparam int unsigned LIVES_W_DEF = 2;
    localparam int unsigned N_CARS_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RESPAWN,
        ST_GAME_OVER
    } mon_state_e;

    // Car width in pixels from its length code: (len+1) tiles, 11 bits so no wrap.
    function automatic logic [COORD_W:0] car_width(input logic [LEN_W-1:0] len);
        return (($bits(car_width))'(len) + 11'd1) * 11'(TILE);
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational bounding-box test of one car against the frog; off-screen cars never collide.
module box_overlap
    import game_pkg::*;
(
    input  logic [COORD_W-1:0] car_x_i,
    input  logic [COORD_W-1:0] car_y_i,
    input  logic [LEN_W-1:0]   car_len_i,
    input  logic [COORD_W-1:0] frog_x_i,
    input  logic [COORD_W-1:0] frog_y_i,
    output logic               overlap_o
);

    logic [COORD_W:0] cx;
    logic [COORD_W:0] cy;
    logic [COORD_W:0] fx;
    logic [COORD_W:0] fy;
    logic             on_screen;
    logic             x_hit;
    logic             y_hit;

    // Strict compares make touching edges a miss.
    always_comb begin
        cx        = {1'b0, car_x_i};
        cy        = {1'b0, car_y_i};
        fx        = {1'b0, frog_x_i};
        fy        = {1'b0, frog_y_i};
        on_screen = cx < 11'(H_DISPLAY);
        x_hit     = (cx < fx + 11'(FROG_SIZE)) && (fx < cx + car_width(car_len_i));
        y_hit     = (cy < fy + 11'(CAR_H)) && (fy < cy + 11'(FROG_SIZE));
        overlap_o = on_screen && x_hit && y_hit;
    end

endmodule

// File: rtl/frog_collision_monitor.sv
// Per-frame sequential car/frog collision scan with lives, respawn handshake and game-over.
module frog_collision_monitor
    import game_pkg::*;
#(
    parameter int unsigned N_CARS  = N_CARS_DEF,
    parameter int unsigned LIVES_W = LIVES_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_tick,
    input  logic [COORD_W*N_CARS-1:0]   car_x_bus,
    input  logic [COORD_W*N_CARS-1:0]   car_y_bus,
    input  logic [LEN_W*N_CARS-1:0]     car_len_bus,
    input  logic [COORD_W-1:0]          frog_x,
    input  logic [COORD_W-1:0]          frog_y,
    input  logic                        respawn_ack,
    input  logic                        restart,
    output logic                        hit,
    output logic [LIVES_W-1:0]          lives,
    output logic                        respawn_req,
    output logic                        game_over,
    output logic                        busy
);

    localparam int unsigned IDX_W = (N_CARS > 1) ? $clog2(N_CARS) : 1;

    mon_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [COORD_W-1:0] snap_x_q, snap_x_d;
    logic [COORD_W-1:0] snap_y_q, snap_y_d;
    logic               hit_q, hit_d;

    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic [LEN_W-1:0]   cur_len;
    logic               overlap;

    // Car positions are taken live from the buses; only the frog is snapshotted.
    always_comb begin
        cur_x   = '0;
        cur_y   = '0;
        cur_len = '0;
        for (int unsigned i = 0; i < N_CARS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_x   = car_x_bus[COORD_W*i +: COORD_W];
                cur_y   = car_y_bus[COORD_W*i +: COORD_W];
                cur_len = car_len_bus[LEN_W*i +: LEN_W];
            end
        end
    end

    box_overlap u_box_overlap (
        .car_x_i   (cur_x),
        .car_y_i   (cur_y),
        .car_len_i (cur_len),
        .frog_x_i  (snap_x_q),
        .frog_y_i  (snap_y_q),
        .overlap_o (overlap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            lives_q  <= LIVES_W'(LIVES_INIT);
            snap_x_q <= '0;
            snap_y_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            lives_q  <= lives_d;
            snap_x_q <= snap_x_d;
            snap_y_q <= snap_y_d;
            hit_q    <= hit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lives_d  = lives_q;
        snap_x_d = snap_x_q;
        snap_y_d = snap_y_q;
        hit_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    snap_x_d = frog_x;
                    snap_y_d = frog_y;
                    idx_d    = '0;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // First overlapping car ends the scan, so one frame costs at most one life.
                if (overlap) begin
                    hit_d = 1'b1;
                    if (lives_q <= LIVES_W'(1)) begin
                        lives_d = '0;
                        state_d = ST_GAME_OVER;
                    end else begin
                        lives_d = lives_q - LIVES_W'(1);
                        state_d = ST_RESPAWN;
                    end
                end else if (idx_q == IDX_W'(N_CARS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_RESPAWN: begin
                if (respawn_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAME_OVER: begin
                if (restart) begin
                    lives_d = LIVES_W'(LIVES_INIT);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hit         = hit_q;
        lives       = lives_q;
        respawn_req = (state_q == ST_RESPAWN);
        game_over   = (state_q == ST_GAME_OVER);
        busy        = (state_q != ST_IDLE);
    end

endmodule
